// File: rtl/ecpu_pkg.sv
// Shared constants for the ecpu bus responder: memory/I-O map, mailbox status layout.
package ecpu_pkg;

  localparam logic [15:0] ROM_BASE     = 16'h0000;
  localparam logic [15:0] RAM_BASE     = 16'h8000;
  localparam logic [15:0] MBOX_DATA    = 16'hC000;
  localparam logic [15:0] MBOX_STAT    = 16'hC001;
  localparam logic [7:0]  IO_PORT_OUT  = 8'h00;
  localparam logic [7:0]  IACK_VEC_DEF = 8'hFF;

  localparam int ST_IN_FULL  = 0;
  localparam int ST_OUT_FULL = 1;
  localparam int ST_OVR      = 2;

  typedef enum logic [1:0] {
    SRC_ROM,
    SRC_RAM,
    SRC_BYTE
  } rd_src_e;

  // Bit 2 carries the overrun flag owned by whichever side reads the status.
  function automatic logic [7:0] status_byte(input logic ovr, input logic out_full,
                                             input logic in_full);
    status_byte              = 8'h00;
    status_byte[ST_OVR]      = ovr;
    status_byte[ST_OUT_FULL] = out_full;
    status_byte[ST_IN_FULL]  = in_full;
  endfunction

endpackage

// File: rtl/ecpu_mailbox.sv
// Two-way byte mailbox between ecpu and host; a set and a clear of a flag in the
// same cycle resolve as set, so a byte or an overrun is never silently dropped.
module ecpu_mailbox
  import ecpu_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_ecpu_wr_data,
  input  logic [7:0] i_ecpu_wdata,
  input  logic       i_ecpu_rd_data,
  input  logic       i_ecpu_rd_stat,
  input  logic       i_host_wr_data,
  input  logic [7:0] i_host_wdata,
  input  logic       i_host_rd_data,
  input  logic       i_host_rd_stat,
  output logic [7:0] o_in_data,
  output logic [7:0] o_out_data,
  output logic       o_in_full,
  output logic       o_out_full,
  output logic       o_in_ovr,
  output logic       o_out_ovr
);

  logic [7:0] r_in_data, r_out_data;
  logic       r_in_full, r_out_full, r_in_ovr, r_out_ovr;

  always_ff @(posedge clk_sys) begin
    if (i_host_wr_data) r_in_data <= i_host_wdata;
    if (i_ecpu_wr_data) r_out_data <= i_ecpu_wdata;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_in_full  <= 1'b0;
      r_out_full <= 1'b0;
      r_in_ovr   <= 1'b0;
      r_out_ovr  <= 1'b0;
    end else begin
      if (i_host_wr_data)                 r_in_full  <= 1'b1;
      else if (i_ecpu_rd_data)            r_in_full  <= 1'b0;
      if (i_host_wr_data && r_in_full)    r_in_ovr   <= 1'b1;
      else if (i_ecpu_rd_stat)            r_in_ovr   <= 1'b0;
      if (i_ecpu_wr_data)                 r_out_full <= 1'b1;
      else if (i_host_rd_data)            r_out_full <= 1'b0;
      if (i_ecpu_wr_data && r_out_full)   r_out_ovr  <= 1'b1;
      else if (i_host_rd_stat)            r_out_ovr  <= 1'b0;
    end
  end

  assign o_in_data  = r_in_data;
  assign o_out_data = r_out_data;
  assign o_in_full  = r_in_full;
  assign o_out_full = r_out_full;
  assign o_in_ovr   = r_in_ovr;
  assign o_out_ovr  = r_out_ovr;

endmodule

// File: rtl/ecpu_bus_resp.sv
// ecpu Z80 bus target: address decode, strobe edge detect, work RAM, read mux,
// I/O output latch and host-facing mailbox port.
module ecpu_bus_resp
  import ecpu_pkg::*;
#(
  parameter int         RAM_AW   = 11,
  parameter int         ROM_AW   = 15,
  parameter logic [7:0] IACK_VEC = IACK_VEC_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [15:0]       ecpu_ab,
  input  logic [7:0]        ecpu_dout,
  input  logic              ecpu_rd,
  input  logic              ecpu_wr,
  input  logic              ecpu_mreq,
  input  logic              ecpu_io,
  output logic [7:0]        ecpu_din,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              host_cs,
  input  logic              host_a0,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [7:0]        host_din,
  output logic [7:0]        host_dout,
  output logic              host_irq,
  output logic [7:0]        ecpu_port
);

  logic w_rd_mem, w_wr_mem, w_wr_io, w_host_rd, w_host_wr;
  logic r_rd_mem_q, r_wr_mem_q, r_wr_io_q, r_host_rd_q, r_host_wr_q;
  logic w_rd_mem_rise, w_wr_mem_rise, w_wr_io_rise, w_host_rd_rise, w_host_wr_rise;
  logic w_is_rom, w_is_ram, w_is_mdata, w_is_mstat, w_hold;
  logic [7:0] w_in_data, w_out_data, w_byte;
  logic w_in_full, w_out_full, w_in_ovr, w_out_ovr;
  rd_src_e w_src, r_src_p1;
  logic [7:0] r_byte_p1, r_ram_p1;
  logic [7:0] r_ram [2**RAM_AW];

  assign w_rd_mem  = ecpu_rd & ecpu_mreq;
  assign w_wr_mem  = ecpu_wr & ecpu_mreq;
  assign w_wr_io   = ecpu_wr & ecpu_io;
  assign w_host_rd = host_cs & host_rd;
  assign w_host_wr = host_cs & host_wr;

  // Previous-strobe registers come out of reset high so a strobe still held
  // across reset release does not fire a late side effect.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_rd_mem_q  <= 1'b1;
      r_wr_mem_q  <= 1'b1;
      r_wr_io_q   <= 1'b1;
      r_host_rd_q <= 1'b1;
      r_host_wr_q <= 1'b1;
    end else begin
      r_rd_mem_q  <= w_rd_mem;
      r_wr_mem_q  <= w_wr_mem;
      r_wr_io_q   <= w_wr_io;
      r_host_rd_q <= w_host_rd;
      r_host_wr_q <= w_host_wr;
    end
  end

  assign w_rd_mem_rise  = reset_n & w_rd_mem  & ~r_rd_mem_q;
  assign w_wr_mem_rise  = reset_n & w_wr_mem  & ~r_wr_mem_q;
  assign w_wr_io_rise   = reset_n & w_wr_io   & ~r_wr_io_q;
  assign w_host_rd_rise = reset_n & w_host_rd & ~r_host_rd_q;
  assign w_host_wr_rise = reset_n & w_host_wr & ~r_host_wr_q;

  assign w_is_rom   = (ecpu_ab[15] == ROM_BASE[15]);
  assign w_is_ram   = (ecpu_ab[15:14] == RAM_BASE[15:14]);
  assign w_is_mdata = (ecpu_ab == MBOX_DATA);
  assign w_is_mstat = (ecpu_ab == MBOX_STAT);

  ecpu_mailbox u_mailbox (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .i_ecpu_wr_data (w_wr_mem_rise & w_is_mdata),
    .i_ecpu_wdata   (ecpu_dout),
    .i_ecpu_rd_data (w_rd_mem_rise & w_is_mdata),
    .i_ecpu_rd_stat (w_rd_mem_rise & w_is_mstat),
    .i_host_wr_data (w_host_wr_rise & ~host_a0),
    .i_host_wdata   (host_din),
    .i_host_rd_data (w_host_rd_rise & ~host_a0),
    .i_host_rd_stat (w_host_rd_rise & host_a0),
    .o_in_data      (w_in_data),
    .o_out_data     (w_out_data),
    .o_in_full      (w_in_full),
    .o_out_full     (w_out_full),
    .o_in_ovr       (w_in_ovr),
    .o_out_ovr      (w_out_ovr)
  );

  always_comb begin
    w_src  = SRC_BYTE;
    w_byte = 8'hFF;
    if (ecpu_io) begin
      if (!ecpu_rd && !ecpu_wr)              w_byte = IACK_VEC;
      else if (ecpu_ab[7:0] == IO_PORT_OUT)  w_byte = ecpu_port;
    end else if (w_is_rom) begin
      w_src = SRC_ROM;
    end else if (w_is_ram) begin
      w_src = SRC_RAM;
    end else if (w_is_mdata) begin
      w_byte = w_in_data;
    end else if (w_is_mstat) begin
      w_byte = status_byte(w_in_ovr, w_out_full, w_in_full);
    end
  end

  // Mailbox reads clear flags on the strobe edge; freeze the byte captured at
  // that edge for the rest of the strobe so the CPU sees the pre-clear value.
  assign w_hold = w_rd_mem & r_rd_mem_q & ~ecpu_io & (w_is_mdata | w_is_mstat);

  // Stage p1: address registered, RAM read, source decoded
  always_ff @(posedge clk_sys) begin
    if (w_wr_mem_rise && w_is_ram) r_ram[ecpu_ab[RAM_AW-1:0]] <= ecpu_dout;
    r_ram_p1 <= r_ram[ecpu_ab[RAM_AW-1:0]];
    r_src_p1 <= w_src;
    if (!w_hold) r_byte_p1 <= w_byte;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) rom_addr <= '0;
    else          rom_addr <= ecpu_ab[ROM_AW-1:0];
  end

  // Stage p2: read data to CPU
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ecpu_din <= 8'h00;
    end else begin
      case (r_src_p1)
        SRC_ROM: ecpu_din <= rom_data;
        SRC_RAM: ecpu_din <= r_ram_p1;
        default: ecpu_din <= r_byte_p1;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      host_dout <= 8'h00;
      host_irq  <= 1'b0;
      ecpu_port <= 8'h00;
    end else begin
      if (w_host_rd_rise && !host_a0)     host_dout <= w_out_data;
      else if (w_host_rd_rise && host_a0) host_dout <= status_byte(w_out_ovr, w_out_full, w_in_full);
      host_irq <= w_out_full;
      if (w_wr_io_rise && ecpu_ab[7:0] == IO_PORT_OUT) ecpu_port <= ecpu_dout;
    end
  end

endmodule
